// File: rtl/bpred_table_ctrl_if.sv
// Lookup, update, table-port and performance-counter signals of bpred_table_ctrl.
interface bpred_table_ctrl_if #(
    parameter int unsigned IDX_W = 4
);
    logic             lk_valid;
    logic [IDX_W-1:0] lk_idx;
    logic             lk_ready;
    logic             lk_pred_valid;
    logic             lk_pred;
    logic [1:0]       lk_ctr;

    logic             up_valid;
    logic [IDX_W-1:0] up_idx;
    logic             up_outcome;
    logic             up_ready;

    logic             tbl_en;
    logic             tbl_we;
    logic [IDX_W-1:0] tbl_addr;
    logic [1:0]       tbl_wdata;
    logic [1:0]       tbl_rdata;

    logic [15:0]      perf_lk_cnt;
    logic [15:0]      perf_up_cnt;
    logic [15:0]      perf_stall_cnt;

    modport slave (
        input  lk_valid, lk_idx, up_valid, up_idx, up_outcome, tbl_rdata,
        output lk_ready, lk_pred_valid, lk_pred, lk_ctr, up_ready,
               tbl_en, tbl_we, tbl_addr, tbl_wdata,
               perf_lk_cnt, perf_up_cnt, perf_stall_cnt
    );

    modport master (
        output lk_valid, lk_idx, up_valid, up_idx, up_outcome, tbl_rdata,
        input  lk_ready, lk_pred_valid, lk_pred, lk_ctr, up_ready,
               tbl_en, tbl_we, tbl_addr, tbl_wdata,
               perf_lk_cnt, perf_up_cnt, perf_stall_cnt
    );
endinterface

// File: rtl/bpred_table_ctrl.sv
// 2-bit branch predictor table controller: init sweep, lookups, queued read-modify-write updates.
// Optional performance counters are built when BPRED_PERF_EN is defined.
module bpred_table_ctrl #(
    parameter int unsigned IDX_W      = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic               clk,
    input logic               reset,
    bpred_table_ctrl_if.slave bus
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_UPD_WR
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_init_idx;
    logic [IDX_W:0]   r_q_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_q_wr;
    logic [PTR_W-1:0] r_q_rd;
    logic [CNT_W-1:0] r_q_cnt;
    logic [IDX_W-1:0] r_upd_idx;
    logic             r_upd_out;
    logic             r_lk_pred_valid;

    logic             w_full;
    logic             w_empty;
    logic [IDX_W:0]   w_q_head;
    logic             w_push;
    logic             w_pop;
    logic             w_lk_acc;
    logic             w_lk_ready;
    logic             w_up_ready;
    logic             w_tbl_en;
    logic             w_tbl_we;
    logic [IDX_W-1:0] w_tbl_addr;
    logic [1:0]       w_tbl_wdata;
    logic [1:0]       w_sat;
    logic             w_pv;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == FIFO_DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_full     = (r_q_cnt == CNT_W'(FIFO_DEPTH));
    assign w_empty    = (r_q_cnt == '0);
    assign w_q_head   = r_q_mem[r_q_rd];
    assign w_up_ready = !reset && !w_full && (r_state != ST_INIT);
    assign w_push     = bus.up_valid && w_up_ready;

    // Saturating 2-bit counter step for the update being written back
    always_comb begin
        w_sat = bus.tbl_rdata;
        if (r_upd_out) begin
            if (bus.tbl_rdata != 2'b11) w_sat = bus.tbl_rdata + 2'b01;
        end else if (bus.tbl_rdata != 2'b00) begin
            w_sat = bus.tbl_rdata - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_INIT;
        else       r_state <= w_state_nxt;
    end

    // Next state and table-port arbitration; a full queue outranks lookups
    always_comb begin
        w_state_nxt = r_state;
        w_tbl_en    = 1'b0;
        w_tbl_we    = 1'b0;
        w_tbl_addr  = '0;
        w_tbl_wdata = 2'b00;
        w_lk_ready  = 1'b0;
        w_lk_acc    = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_tbl_en    = 1'b1;
                w_tbl_we    = 1'b1;
                w_tbl_addr  = r_init_idx;
                w_tbl_wdata = 2'b01;
                if (r_init_idx == {IDX_W{1'b1}}) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                w_lk_ready = !w_full;
                if (w_full || (!bus.lk_valid && !w_empty)) begin
                    w_tbl_en    = 1'b1;
                    w_tbl_addr  = w_q_head[IDX_W-1:0];
                    w_pop       = 1'b1;
                    w_state_nxt = ST_UPD_WR;
                end else if (bus.lk_valid) begin
                    w_tbl_en   = 1'b1;
                    w_tbl_addr = bus.lk_idx;
                    w_lk_acc   = 1'b1;
                end
            end
            ST_UPD_WR: begin
                w_tbl_en    = 1'b1;
                w_tbl_we    = 1'b1;
                w_tbl_addr  = r_upd_idx;
                w_tbl_wdata = w_sat;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_INIT;
        endcase
        if (reset) begin
            w_state_nxt = ST_INIT;
            w_tbl_en    = 1'b0;
            w_tbl_we    = 1'b0;
            w_tbl_addr  = '0;
            w_tbl_wdata = 2'b00;
            w_lk_ready  = 1'b0;
            w_lk_acc    = 1'b0;
            w_pop       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_init_idx      <= '0;
            r_q_wr          <= '0;
            r_q_rd          <= '0;
            r_q_cnt         <= '0;
            r_upd_idx       <= '0;
            r_upd_out       <= 1'b0;
            r_lk_pred_valid <= 1'b0;
        end else begin
            if (r_state == ST_INIT) r_init_idx <= r_init_idx + IDX_W'(1);
            if (w_push) r_q_wr <= ptr_inc(r_q_wr);
            if (w_pop) begin
                r_q_rd    <= ptr_inc(r_q_rd);
                r_upd_idx <= w_q_head[IDX_W-1:0];
                r_upd_out <= w_q_head[IDX_W];
            end
            case ({w_push, w_pop})
                2'b10:   r_q_cnt <= r_q_cnt + CNT_W'(1);
                2'b01:   r_q_cnt <= r_q_cnt - CNT_W'(1);
                default: r_q_cnt <= r_q_cnt;
            endcase
            r_lk_pred_valid <= w_lk_acc;
        end
    end

    // Queue storage needs no reset: occupancy is tracked by r_q_cnt
    always_ff @(posedge clk) begin
        if (w_push) r_q_mem[r_q_wr] <= {bus.up_outcome, bus.up_idx};
    end

    assign w_pv              = r_lk_pred_valid && !reset;
    assign bus.lk_ready      = w_lk_ready;
    assign bus.up_ready      = w_up_ready;
    assign bus.lk_pred_valid = w_pv;
    assign bus.lk_ctr        = w_pv ? bus.tbl_rdata : 2'b00;
    assign bus.lk_pred       = w_pv && bus.tbl_rdata[1];
    assign bus.tbl_en        = w_tbl_en;
    assign bus.tbl_we        = w_tbl_we;
    assign bus.tbl_addr      = w_tbl_addr;
    assign bus.tbl_wdata     = w_tbl_wdata;

`ifdef BPRED_PERF_EN
    logic [15:0] r_perf_lk;
    logic [15:0] r_perf_up;
    logic [15:0] r_perf_stall;
    logic        w_stall;

    assign w_stall = bus.lk_valid && !w_lk_ready && (r_state != ST_INIT);

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_lk    <= 16'h0000;
            r_perf_up    <= 16'h0000;
            r_perf_stall <= 16'h0000;
        end else begin
            if (w_lk_acc && (r_perf_lk != 16'hFFFF))   r_perf_lk    <= r_perf_lk + 16'd1;
            if (w_push && (r_perf_up != 16'hFFFF))     r_perf_up    <= r_perf_up + 16'd1;
            if (w_stall && (r_perf_stall != 16'hFFFF)) r_perf_stall <= r_perf_stall + 16'd1;
        end
    end

    assign bus.perf_lk_cnt    = reset ? 16'h0000 : r_perf_lk;
    assign bus.perf_up_cnt    = reset ? 16'h0000 : r_perf_up;
    assign bus.perf_stall_cnt = reset ? 16'h0000 : r_perf_stall;
`else
    assign bus.perf_lk_cnt    = 16'h0000;
    assign bus.perf_up_cnt    = 16'h0000;
    assign bus.perf_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_bpred_table_ctrl.sv
// Self-checking bench for bpred_table_ctrl: directed vector table, cycle-exact corner cases,
// and randomized traffic against a queue-based reference model.
module tb_bpred_table_ctrl;

    localparam int unsigned IDX_W = 4;
    localparam int          FD    = 2;
    localparam int          N_ENT = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bpred_table_ctrl_if #(.IDX_W(IDX_W)) bus ();

    bpred_table_ctrl #(.IDX_W(IDX_W), .FIFO_DEPTH(FD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Single-port table RAM, read data registered
    logic [1:0] ram [N_ENT];
    always @(posedge clk) begin
        if (bus.tbl_en) begin
            if (bus.tbl_we) ram[bus.tbl_addr] <= bus.tbl_wdata;
            else            bus.tbl_rdata     <= ram[bus.tbl_addr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int mdl_tbl [N_ENT];

    typedef struct {
        bit         is_lk;
        int         idx;
        bit         outc;
        logic [1:0] exp;
    } vec_t;
    vec_t vecs [17];

    function automatic int sat(input int c, input bit t);
        if (t) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.lk_valid   = 1'b0;
        bus.lk_idx     = '0;
        bus.up_valid   = 1'b0;
        bus.up_idx     = '0;
        bus.up_outcome = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {bus.lk_ready, bus.lk_pred_valid, bus.lk_pred, bus.lk_ctr, bus.up_ready,
                   bus.tbl_en, bus.tbl_we, bus.tbl_addr, bus.tbl_wdata}, 32'd0);
        chk({name, "_perf"}, 32'(|{bus.perf_lk_cnt, bus.perf_up_cnt, bus.perf_stall_cnt}), 32'd0);
    endtask

    // Called at the first cycle after reset release
    task automatic check_init_sweep();
        for (int i = 0; i < N_ENT; i++) begin
            chk($sformatf("init_port_%0d", i),
                {bus.tbl_en, bus.tbl_we, bus.tbl_addr, bus.tbl_wdata}, {1'b1, 1'b1, 4'(i), 2'b01});
            chk($sformatf("init_ready_%0d", i), {bus.lk_ready, bus.up_ready}, 32'd0);
            @(negedge clk); #1;
        end
        chk("lk_ready_cycle17", bus.lk_ready, 32'd1);
        for (int i = 0; i < N_ENT; i++) mdl_tbl[i] = 1;
    endtask

    task automatic do_lookup(input int idx, input logic [1:0] exp);
        int guard;
        @(negedge clk);
        bus.lk_valid = 1'b1;
        bus.lk_idx   = 4'(idx);
        #1;
        guard = 0;
        while (!bus.lk_ready && guard < 10) begin
            @(negedge clk); #1;
            guard++;
        end
        chk("lk_accept", bus.lk_ready, 32'd1);
        @(negedge clk);
        bus.lk_valid = 1'b0;
        #1;
        chk($sformatf("lk_pred_valid_%0d", idx), bus.lk_pred_valid, 32'd1);
        chk($sformatf("lk_ctr_%0d", idx), bus.lk_ctr, exp);
        chk($sformatf("lk_pred_%0d", idx), bus.lk_pred, exp[1]);
    endtask

    task automatic do_update(input int idx, input bit outc);
        int guard;
        @(negedge clk);
        bus.up_valid   = 1'b1;
        bus.up_idx     = 4'(idx);
        bus.up_outcome = outc;
        #1;
        guard = 0;
        while (!bus.up_ready && guard < 10) begin
            @(negedge clk); #1;
            guard++;
        end
        chk("up_accept", bus.up_ready, 32'd1);
        @(negedge clk);
        bus.up_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        mdl_tbl[idx] = sat(mdl_tbl[idx], outc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int q_m[$];
        bit m_wr, m_pv;
        int m_wr_e, m_pv_ctr, e, p_lk, p_up, p_st, stall0;
        bit lv, uv, uo, e_lr, e_ur;
        int li, ui;

        vecs[0]  = '{1'b1, 3,  1'b0, 2'b01};
        vecs[1]  = '{1'b0, 5,  1'b1, 2'b00};
        vecs[2]  = '{1'b0, 5,  1'b1, 2'b00};
        vecs[3]  = '{1'b0, 5,  1'b1, 2'b00};
        vecs[4]  = '{1'b1, 5,  1'b0, 2'b11};
        vecs[5]  = '{1'b0, 5,  1'b1, 2'b00};
        vecs[6]  = '{1'b1, 5,  1'b0, 2'b11};
        vecs[7]  = '{1'b0, 5,  1'b0, 2'b00};
        vecs[8]  = '{1'b0, 5,  1'b0, 2'b00};
        vecs[9]  = '{1'b1, 5,  1'b0, 2'b01};
        vecs[10] = '{1'b0, 0,  1'b0, 2'b00};
        vecs[11] = '{1'b1, 0,  1'b0, 2'b00};
        vecs[12] = '{1'b0, 0,  1'b0, 2'b00};
        vecs[13] = '{1'b1, 0,  1'b0, 2'b00};
        vecs[14] = '{1'b0, 15, 1'b1, 2'b00};
        vecs[15] = '{1'b1, 15, 1'b0, 2'b10};
        vecs[16] = '{1'b1, 7,  1'b0, 2'b01};

        idle_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset_outputs");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_init_sweep();

        // Directed vector table
        for (int v = 0; v < 17; v++) begin
            if (vecs[v].is_lk) do_lookup(vecs[v].idx, vecs[v].exp);
            else               do_update(vecs[v].idx, vecs[v].outc);
        end

        // Queue fills while lookups are held; update read must win for two cycles
        @(negedge clk);
        bus.lk_valid = 1'b1; bus.lk_idx = 4'd1;
        bus.up_valid = 1'b1; bus.up_idx = 4'd9; bus.up_outcome = 1'b1;
        #1;
        chk("full_a_lk_ready", bus.lk_ready, 32'd1);
        @(negedge clk);
        bus.lk_idx = 4'd2; bus.up_idx = 4'd10; bus.up_outcome = 1'b0;
        #1;
        chk("full_b_lk_ready", bus.lk_ready, 32'd1);
        chk("full_b_up_ready", bus.up_ready, 32'd1);
        @(negedge clk);
        bus.up_valid = 1'b0;
        #1;
        chk("full_c_lk_ready", bus.lk_ready, 32'd0);
        chk("full_c_up_ready", bus.up_ready, 32'd0);
        chk("full_c_port", {bus.tbl_en, bus.tbl_we, bus.tbl_addr}, {1'b1, 1'b0, 4'd9});
        stall0 = int'(bus.perf_stall_cnt);
        @(negedge clk); #1;
        chk("full_d_lk_ready", bus.lk_ready, 32'd0);
        chk("full_d_port", {bus.tbl_en, bus.tbl_we, bus.tbl_addr, bus.tbl_wdata},
            {1'b1, 1'b1, 4'd9, 2'(sat(mdl_tbl[9], 1'b1))});
        mdl_tbl[9] = sat(mdl_tbl[9], 1'b1);
        @(negedge clk); #1;
        chk("full_e_lk_ready", bus.lk_ready, 32'd1);
`ifdef BPRED_PERF_EN
        chk("full_stall_cnt", bus.perf_stall_cnt, 32'(stall0 + 2));
`else
        chk("full_stall_cnt", bus.perf_stall_cnt, 32'd0);
`endif
        @(negedge clk);
        bus.lk_valid = 1'b0;
        #1;
        chk("full_f_pred_valid", bus.lk_pred_valid, 32'd1);
        chk("full_f_ctr", bus.lk_ctr, 32'(mdl_tbl[2]));
        chk("full_f_port", {bus.tbl_en, bus.tbl_we, bus.tbl_addr}, {1'b1, 1'b0, 4'd10});
        @(negedge clk); #1;
        chk("full_g_port", {bus.tbl_en, bus.tbl_we, bus.tbl_addr, bus.tbl_wdata},
            {1'b1, 1'b1, 4'd10, 2'(sat(mdl_tbl[10], 1'b0))});
        mdl_tbl[10] = sat(mdl_tbl[10], 1'b0);
        @(negedge clk); #1;

        // Same-cycle lookup and update on empty queue: lookup first, no forwarding
        @(negedge clk);
        bus.lk_valid = 1'b1; bus.lk_idx = 4'd4;
        bus.up_valid = 1'b1; bus.up_idx = 4'd4; bus.up_outcome = 1'b1;
        #1;
        chk("same_a_lk_ready", bus.lk_ready, 32'd1);
        chk("same_a_port", {bus.tbl_en, bus.tbl_we, bus.tbl_addr}, {1'b1, 1'b0, 4'd4});
        @(negedge clk);
        idle_inputs();
        #1;
        chk("same_b_pred_valid", bus.lk_pred_valid, 32'd1);
        chk("same_b_ctr", bus.lk_ctr, 32'(mdl_tbl[4]));
        chk("same_b_port", {bus.tbl_en, bus.tbl_we, bus.tbl_addr}, {1'b1, 1'b0, 4'd4});
        @(negedge clk); #1;
        chk("same_c_port", {bus.tbl_en, bus.tbl_we, bus.tbl_addr, bus.tbl_wdata},
            {1'b1, 1'b1, 4'd4, 2'(sat(mdl_tbl[4], 1'b1))});
        mdl_tbl[4] = sat(mdl_tbl[4], 1'b1);
        @(negedge clk); #1;

        // Reset landing on the write cycle drops it; reset mid-sweep restarts at 0
        @(negedge clk);
        bus.up_valid = 1'b1; bus.up_idx = 4'd6; bus.up_outcome = 1'b1;
        @(negedge clk);
        bus.up_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_wr_port", {bus.tbl_en, bus.tbl_we}, 32'd0);
        chk_all_zero("rst_wr_outputs");
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("resweep_first_addr", {bus.tbl_we, bus.tbl_addr}, {1'b1, 4'd0});
        repeat (5) @(negedge clk);
        #1;
        chk("resweep_mid_addr", {bus.tbl_we, bus.tbl_addr}, {1'b1, 4'd5});
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_init_sweep();

        // Randomized traffic against the reference model, then a drain period
        m_wr = 1'b0; m_pv = 1'b0; m_wr_e = 0; m_pv_ctr = 0;
        p_lk = 0; p_up = 0; p_st = 0;
        for (int cyc = 0; cyc < 640; cyc++) begin
            if (cyc < 600) begin
                lv = ($urandom_range(0, 9) < 6);
                uv = ($urandom_range(0, 9) < 5);
            end else begin
                lv = 1'b0;
                uv = 1'b0;
            end
            li = int'($urandom_range(0, N_ENT - 1));
            ui = int'($urandom_range(0, N_ENT - 1));
            uo = 1'($urandom_range(0, 1));
            bus.lk_valid = lv; bus.lk_idx = 4'(li);
            bus.up_valid = uv; bus.up_idx = 4'(ui); bus.up_outcome = uo;
            #1;
            e_lr = !m_wr && (q_m.size() < FD);
            e_ur = (q_m.size() < FD);
            chk("rnd_lk_ready", bus.lk_ready, 32'(e_lr));
            chk("rnd_up_ready", bus.up_ready, 32'(e_ur));
            chk("rnd_pred_valid", bus.lk_pred_valid, 32'(m_pv));
            if (m_pv) chk("rnd_ctr", bus.lk_ctr, 32'(m_pv_ctr));
            if (lv && !e_lr) p_st++;
            m_pv = 1'b0;
            if (m_wr) begin
                mdl_tbl[m_wr_e / 2] = sat(mdl_tbl[m_wr_e / 2], m_wr_e % 2 == 1);
                m_wr = 1'b0;
            end else if (q_m.size() == FD || (!lv && q_m.size() > 0)) begin
                m_wr_e = q_m.pop_front();
                m_wr   = 1'b1;
            end else if (lv) begin
                m_pv     = 1'b1;
                m_pv_ctr = mdl_tbl[li];
                p_lk++;
            end
            if (uv && e_ur) begin
                e = ui * 2 + int'(uo);
                q_m.push_back(e);
                p_up++;
            end
            @(negedge clk);
        end
        idle_inputs();
        #1;
        for (int i = 0; i < N_ENT; i++)
            chk($sformatf("final_tbl_%0d", i), ram[i], 32'(mdl_tbl[i]));
`ifdef BPRED_PERF_EN
        chk("perf_lk", bus.perf_lk_cnt, 32'(p_lk));
        chk("perf_up", bus.perf_up_cnt, 32'(p_up));
        chk("perf_stall", bus.perf_stall_cnt, 32'(p_st));
`else
        chk("perf_lk", bus.perf_lk_cnt, 32'd0);
        chk("perf_up", bus.perf_up_cnt, 32'd0);
        chk("perf_stall", bus.perf_stall_cnt, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bpred_table_ctrl.md
BPRED_TABLE_CTRL -- requirements
Module: bpred_table_ctrl

Interface
REQ-001 Parameter IDX_W, default 4, table index width; the table has 2^IDX_W entries.
REQ-002 Parameter FIFO_DEPTH, default 2, number of update queue entries; minimum 1.
REQ-003 Clocking SHALL be one clock, clk; reset is synchronous and active-high, reset.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 lk_valid  in  1  fetch-stage lookup request.
REQ-007 lk_idx  in  IDX_W  lookup index.
REQ-008 lk_ready  out  1  lookup accepted this cycle when high with lk_valid.
REQ-009 lk_pred_valid  out  1  registered response strobe.
REQ-010 lk_pred  out  1  predicted taken (counter MSB).
REQ-011 lk_ctr  out  2  full counter value returned.
REQ-012 up_valid  in  1  EX-stage branch resolved.
REQ-013 up_idx  in  IDX_W  index of resolved branch.
REQ-014 up_outcome  in  1  1 = taken.
REQ-015 up_ready  out  1  update queue can accept.
REQ-016 tbl_en, tbl_we  out  1 each  single-port table enable / write enable.
REQ-017 tbl_addr  out  IDX_W  table address; tbl_wdata  out  2; tbl_rdata  in  2, valid the cycle after a read.
REQ-018 perf_lk_cnt, perf_up_cnt, perf_stall_cnt  out  16 each  performance counters.

Function
REQ-019 The FSM SHALL have states INIT, IDLE, UPD_WR; all table port outputs are combinational from the state and the inputs.
REQ-020 INIT: one write per cycle, tbl_en=tbl_we=1, tbl_wdata=2'b01, tbl_addr sweeping 0..2^IDX_W-1; move to IDLE after the last index; lk_ready=up_ready=0 throughout.
REQ-021 IDLE port priority: (1) queue full -> update read of queue head; (2) else lk_valid -> lookup read of lk_idx; (3) else queue non-empty -> update read of head; (4) else tbl_en=0.
REQ-022 lk_ready=1 only in IDLE with the queue not full.
REQ-023 An update read SHALL pop the head, capture idx/outcome, and go to UPD_WR.
REQ-024 UPD_WR: write tbl_addr=captured idx, tbl_wdata=sat(tbl_rdata) in a single cycle, then return to IDLE.
REQ-025 Saturation: outcome 1 -> min(ctr+1,3); outcome 0 -> max(ctr-1,0).
REQ-026 lk_pred_valid SHALL pulse exactly one cycle after acceptance, with lk_ctr=tbl_rdata and lk_pred=tbl_rdata[1]; lookups sustain 1 per cycle when no update is pending.
REQ-027 up_ready = queue not full and state != INIT; a push occurs on up_valid&&up_ready, and a push and a pop in the same cycle are both honoured.
REQ-028 The queue SHALL be FIFO order with wrap-around pointers and must never overflow or underflow.
REQ-029 A lookup to an index with a queued update SHALL return the table value (no forwarding); this is architecturally accepted.

Reset
REQ-030 While reset is high, tbl_en=0 and all outputs are 0.
REQ-031 On reset release, the block SHALL be in INIT at index 0 with an empty queue; reset during UPD_WR drops the write.
REQ-032 Reset asserted mid-INIT SHALL restart the sweep from index 0.

Configuration
REQ-033 Macro BPRED_PERF_EN defined: the performance counters count accepted lookups, pushed updates, and cycles with lk_valid&&!lk_ready outside INIT; each saturates at 16'hFFFF and resets to 0.
REQ-034 Macro BPRED_PERF_EN undefined: no counter logic is built; the perf ports remain and are tied to 0.

Verification
REQ-035 Reset, IDX_W=4 -> 16 INIT write cycles, addr 0..15, wdata 01; lk_ready first high on cycle 17.
REQ-036 Lookup idx 3 after INIT -> next cycle lk_pred_valid=1, lk_ctr=01, lk_pred=0.
REQ-037 Three taken updates to idx 5, then lookup 5 -> lk_ctr=11; a fourth taken update keeps 11; two not-taken updates -> 01.
REQ-038 Queue full with lk_valid held -> update read wins, lk_ready=0 for 2 cycles, perf_stall_cnt +2 (with BPRED_PERF_EN).
REQ-039 up_valid and lookup in the same IDLE cycle, queue empty -> lookup served first, update read the next cycle, write the cycle after.
REQ-040 Reset asserted during UPD_WR -> no write observed, table re-swept to 01.
